// File: rtl/neuron_fork.sv
// Activation stage: clipped-ReLU or identity on NC channels, registered once and
// forked to NB consumers, each with its own valid/ready handshake.
module neuron_fork #(
  parameter string       HIDDEN = "yes",
  parameter int unsigned NP     = 4,
  parameter int unsigned NC     = 8,
  parameter int unsigned WF     = 4,
  parameter int unsigned NB     = 2,
  localparam int unsigned WI    = $clog2(NP) + WF,
  localparam int unsigned WN    = (HIDDEN == "yes") ? WF : WI
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iMode,
  input  logic             iValid_AM_Accum0,
  output logic             oReady_AM_Accum0,
  input  logic [NC*WI-1:0] iData_AM_Accum0,
  output logic [NB-1:0]    oValid_BM_State,
  input  logic [NB-1:0]    iReady_BM_State,
  output logic [NC*WN-1:0] oData_BM_State,
  output logic [NC-1:0]    oMask_BM_State,
  output logic             oMode_BM_State
);

  localparam int SAT = int'(2 ** WF) - 1;

  logic [NC*WN-1:0] act_data;
  logic [NC-1:0]    act_mask;
  logic             accept;

  // Per-channel activation; returns {mask, value}.
  function automatic logic [WN:0] act(input logic [WI-1:0] x);
    int            xi;
    logic [WN-1:0] y;
    logic          m;
    xi = int'($signed(x));
    y  = WN'(xi);
    m  = 1'b1;
    if (HIDDEN == "yes") begin
      if (xi <= 0) begin
        y = '0;
        m = 1'b0;
      end else if (xi > SAT) begin
        y = WN'(SAT);
        m = 1'b0;
      end
    end
    return {m, y};
  endfunction

  always_comb begin
    act_data = '0;
    act_mask = '0;
    for (int i = 0; i < NC; i++) begin
      {act_mask[i], act_data[i*WN +: WN]} = act(iData_AM_Accum0[i*WI +: WI]);
    end
  end

  // Free when every still-pending branch completes this cycle.
  assign oReady_AM_Accum0 = ~|(oValid_BM_State & ~iReady_BM_State);
  assign accept           = iValid_AM_Accum0 & oReady_AM_Accum0;

  // Pending bits double as the per-branch valids; inference serves branch 0 only.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oValid_BM_State <= '0;
      oData_BM_State  <= '0;
      oMask_BM_State  <= '0;
      oMode_BM_State  <= 1'b0;
    end else if (accept) begin
      oValid_BM_State <= iMode ? {NB{1'b1}} : NB'(1);
      oData_BM_State  <= act_data;
      oMask_BM_State  <= act_mask;
      oMode_BM_State  <= iMode;
    end else begin
      oValid_BM_State <= oValid_BM_State & ~iReady_BM_State;
    end
  end

endmodule

// File: doc/neuron_fork.md
Name: neuron_fork

Overview:
- Next-generation neuron activation stage. Takes NC accumulated pre-activations from the accumulator (AM) side and applies the activation.
- Registers the result once and forks it to NB independent downstream consumers (BM side), each with its own valid/ready handshake.
- In inference mode only branch 0 is served. In training mode every branch must consume the result, and a per-channel gradient mask travels with the data for backprop.

Parameters:
- HIDDEN, "yes": "yes" = hidden layer (clipped ReLU); "no" = output layer (identity).
- NP, 4: number of previous-layer neurons; sets accumulator growth bits.
- NC, 8: channel (neuron) count per transfer.
- WF, 4: base fixed-point data width.
- NB, 2: number of output branches, min 1.
- Derived, WI = $clog2(NP)+WF: input width per channel.
- Derived, WN = (HIDDEN=="yes") ? WF : WI: output width per channel.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iMode  in  1  0 = inference, 1 = training; sampled on input accept.
- iValid_AM_Accum0  in  1  input valid.
- oReady_AM_Accum0  out  1  input ready.
- iData_AM_Accum0  in  NC*WI  signed pre-activations; channel i at [i*WI +: WI].
- oValid_BM_State  out  NB  per-branch valid.
- iReady_BM_State  in  NB  per-branch ready.
- oData_BM_State  out  NC*WN  activation result, shared by all branches.
- oMask_BM_State  out  NC  per-channel gradient mask, shared.
- oMode_BM_State  out  1  mode tag of the held entry.

Behaviour:
- Reset (iRST=0, asynchronous): entry empty, all pending flags 0, oValid_BM_State=0, oData=0, oMask=0, oMode=0.
- After release, oReady_AM_Accum0=1.
- Activation, per channel, x signed WI bits:
  - HIDDEN="yes": y=0 if x<0; y=2^WF-1 if x>2^WF-1; else y=x[WF-1:0] (unsigned). mask=1 iff 0<x<=2^WF-1.
  - HIDDEN="no": y=x, all mask bits 1.
- Storage: one output entry holding data, mask, mode, and NB pending bits.
- Input accept: on iValid & oReady at a clock edge.
  - Entry loads the activation of iData; oMode takes iMode.
  - Pending is set to 1 for branch 0 only when iMode=0, and to all ones when iMode=1.
- Latency: one cycle from accept to oValid_BM_State.
- oValid_BM_State[b] = pending[b]. oValid never depends combinationally on iReady.
- Branch handshake: pending[b] clears on the edge where oValid[b] & iReady[b]. Branches complete independently and in any order. Data stays stable until every pending bit is clear.
- Ready rule: oReady_AM_Accum0 = (no pending bits) | (every set pending[b] has iReady[b]=1 this cycle). This gives full throughput: back-to-back accepts when all required consumers are ready.
- Simultaneous last-branch handshake and new accept: the entry is replaced on the same edge and the new pending set is loaded. The old data is never re-presented.
- A branch that has completed stays low (valid=0) while siblings stall. It never sees a duplicate.
- Inference entries never assert oValid[b] for b>0, whatever iReady[b] is.
- iMode changing while the entry is held has no effect on the held entry.
- Reset asserted mid-transfer drops the held entry immediately. No partial handshake survives.
- NB=1: the block degenerates to a one-deep pipeline register with the activation.

Test Plan:
- Basic hidden, iMode=1:
  - NP=4, NC=8, WF=4, NB=2. Input channel i = -7+3i, i.e. {-7,-4,-1,2,5,8,11,14}; both readies held high.
  - -> One cycle later data = {0,0,0,2,5,8,11,14}, mask = {0,0,0,1,1,1,1,1}.
  - -> Both valids high; a new accept every cycle.
- Saturation:
  - Channel values {20, 31, 15, 0, -32, 1, 16, -1}.
  - -> data = {15,15,15,0,0,1,15,0}, mask = {0,0,1,0,0,1,0,0}.
- Independent branch stall, iMode=1:
  - iReady_BM_State=2'b01 for 3 cycles, then 2'b10.
  - -> Branch 0 valid drops after 1 cycle; branch 1 valid holds 4 cycles.
  - -> oReady=0 during the stall, rising in the cycle iReady[1]=1. Data unchanged throughout.
- Inference mode:
  - iMode=0, iReady_BM_State=2'b01.
  - -> oValid[1] never asserts, throughput of 1 per cycle, oMode_BM_State=0.
- Output layer:
  - HIDDEN="no", same input as scenario 1.
  - -> data = {-7,-4,-1,2,5,8,11,14} as 6-bit signed, mask = 8'hFF.
- Reset mid-transfer:
  - Pull iRST low while branch 1 is pending.
  - -> All valids 0 asynchronously, data 0. After release, oReady=1 and no stale output appears.
